// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Function : iterative shift-add multiplier for mult/multu, start/busy/done
//            handshake, flush abort, HI/LO result registers
// Revision : 1.0
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               neg_q,    neg_d;

  logic                      a_neg, b_neg;
  logic [WIDTH-1:0]          a_mag, b_mag;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [2*WIDTH-1:0]        partial;
  logic [2*WIDTH-1:0]        result;
  logic                      idle_or_done;
  logic                      accept;

  // Negating the most-negative value yields the same pattern, which read as
  // unsigned is exactly its magnitude.
  assign a_neg = is_signed & src_a[WIDTH-1];
  assign b_neg = is_signed & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept       = idle_or_done && start && !flush;

  // Multiplicand is kept pre-shifted, so the digit weight is implicit.
  assign digit   = mplier_q[BITS_PER_CYCLE-1:0];
  assign partial = mcand_q * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, digit};
  assign result  = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        if (flush)                       state_d = S_IDLE;
        else if (count_q == LAST_ITER)   state_d = S_SIGN;
      end
      S_SIGN: state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = accept ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    count_d  = count_q;
    neg_d    = neg_q;
    if (accept) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      count_d  = '0;
      neg_d    = a_neg ^ b_neg;
    end else if (state_q == S_CALC) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      count_d  = count_q + CW'(1);
    end else if ((state_q == S_SIGN) && !flush) begin
      {hi_d, lo_d} = result;
    end
  end

  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_SIGN);
    done = (state_q == S_DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule
`default_nettype wire
